wb_board_mem: RTL
=================

WB_BOARD_MEM -- requirements
Module: wb_board_mem

Interface
REQ-001 Parameter DATA_W, default 8: width of the Wishbone data bus and of each memory word.
REQ-002 Parameter ADDR_W, default 8: width of the Wishbone address bus.
REQ-003 Parameter DEPTH, default 256: number of implemented words; elaboration SHALL fail if DEPTH > 2**ADDR_W or DEPTH < 1.
REQ-004 Parameter WAIT_STATES, default 0: extra cycles inserted before each response; legal range 0..15.
REQ-005 Parameter CLEAR_VAL, default 0: DATA_W-bit value written to every word during a clear.
REQ-006 CLK_I  in  1  single system clock; all state SHALL change on its rising edge except async reset.
REQ-007 RST_I  in  1  asynchronous, active-low reset.
REQ-008 ADR_I  in  ADDR_W  word address from master.
REQ-009 DAT_I  in  DATA_W  write data from master.
REQ-010 DAT_O  out  DATA_W  read data to master, valid only while ACK_O=1.
REQ-011 WE_I  in  1  1=write, 0=read.
REQ-012 STB_I  in  1  transfer strobe.
REQ-013 CYC_I  in  1  bus cycle valid.
REQ-014 ACK_O  out  1  normal termination, one-cycle pulse.
REQ-015 ERR_O  out  1  error termination (address >= DEPTH), one-cycle pulse.
REQ-016 CLR_I  in  1  request a full memory clear (board restart).
REQ-017 BUSY_O  out  1  high while a clear is in progress.

Function
REQ-018 The block SHALL implement a Wishbone classic slave with a state machine of states INIT, IDLE, WAIT, RESP.
REQ-019 INIT: write CLEAR_VAL to address 0..DEPTH-1, one per cycle, ascending; BUSY_O=1; no ACK_O/ERR_O; after address DEPTH-1 go to IDLE (exactly DEPTH cycles in INIT).
REQ-020 IDLE: if CLR_I=1 go to INIT (CLR_I has priority over a simultaneous request, which stays pending and is served after the clear); else if CYC_I&STB_I=1 capture ADR_I, DAT_I, WE_I and go to WAIT if WAIT_STATES>0, else RESP.
REQ-021 WAIT: count WAIT_STATES cycles then go to RESP; if CYC_I or STB_I drops, abort to IDLE with no write and no response.
REQ-022 RESP: registered outputs; ACK_O=1 (or ERR_O=1) for exactly one cycle, then IDLE unconditionally; CLR_I SHALL be ignored outside IDLE.
REQ-023 Latency: request sampled at edge k SHALL produce ACK_O/ERR_O high from edge k+1+WAIT_STATES until edge k+2+WAIT_STATES.
REQ-024 Write: memory word updated at the same edge ACK_O rises, using captured address/data.
REQ-025 Read: DAT_O SHALL equal the word at the captured address while ACK_O=1, and 0 otherwise.
REQ-026 Captured address >= DEPTH: ERR_O instead of ACK_O, no write, DAT_O=0.
REQ-027 Back-to-back: a STB_I still high in the cycle after RESP SHALL be treated as a new transfer (minimum 2 cycles per transfer at WAIT_STATES=0).
REQ-028 ACK_O and ERR_O SHALL never be high simultaneously and never high while BUSY_O=1.
REQ-029 CLR_I held high continuously SHALL restart INIT from each IDLE visit (one IDLE cycle between clears).

Reset
REQ-030 While RST_I=0: ACK_O=0, ERR_O=0, DAT_O=0, BUSY_O=1, state=INIT, clear counter=0; memory contents undefined.
REQ-031 Reset asserted mid-transfer or mid-clear SHALL abort it immediately; after release the clear SHALL restart from address 0.

Verification (DATA_W=8, ADDR_W=8, DEPTH=256 unless noted)
REQ-032 Release RST_I -> BUSY_O=1 for exactly 256 cycles; then reads of 0x00, 0x7F, 0xFF return 0x00 with one-cycle ACK_O.
REQ-033 Write 0xA5 to 0x3C at WAIT_STATES=0, then read 0x3C -> ACK_O one edge after each request, DAT_O=0xA5.
REQ-034 WAIT_STATES=2, read request sampled at edge k -> ACK_O high only between edges k+3 and k+4.
REQ-035 DEPTH=200, write 0x11 to 0xC8 -> ERR_O one cycle, no ACK_O; read 0xC7 returns unchanged value.
REQ-036 WAIT_STATES=3, drop CYC_I after one WAIT cycle of a write 0x55 to 0x10 -> no ACK_O/ERR_O, 0x10 still reads 0x00.
REQ-037 Write 0x0F to 0x20, pulse CLR_I coincident with a read request to 0x20 -> BUSY_O 256 cycles, then read served, DAT_O=0x00.

Source files
------------

// File: rtl/wb_board_mem.sv
// wb_board_mem: Wishbone classic slave RAM with a board-restart clear sequence,
// configurable wait states and error termination for unimplemented addresses.
module wb_board_mem #(
    parameter int unsigned        DATA_W      = 8,
    parameter int unsigned        ADDR_W      = 8,
    parameter int unsigned        DEPTH       = 256,
    parameter int unsigned        WAIT_STATES = 0,
    parameter logic [DATA_W-1:0]  CLEAR_VAL   = '0
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic [ADDR_W-1:0] ADR_I,
    input  logic [DATA_W-1:0] DAT_I,
    output logic [DATA_W-1:0] DAT_O,
    input  logic              WE_I,
    input  logic              STB_I,
    input  logic              CYC_I,
    output logic              ACK_O,
    output logic              ERR_O,
    input  logic              CLR_I,
    output logic              BUSY_O
);

    localparam int unsigned       MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [MEM_AW-1:0] LAST_IDX  = MEM_AW'(DEPTH - 1);
    localparam logic [3:0]        WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
        $error("wb_board_mem: DEPTH must be within 1..2**ADDR_W");
    end
    if (WAIT_STATES > 15) begin : g_bad_wait
        $error("wb_board_mem: WAIT_STATES must be within 0..15");
    end

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t              state_q, state_d;
    logic [MEM_AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic [3:0]          wait_q, wait_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [DATA_W-1:0]   wdat_q, wdat_d;
    logic                we_q, we_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdat_q, rdat_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic                mem_we;
    logic [MEM_AW-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [MEM_AW-1:0]   adr_idx;
    logic                oor;

    assign adr_idx = adr_q[MEM_AW-1:0];
    assign oor     = {1'b0, adr_q} >= DEPTH_L;

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= '0;
            wait_q    <= '0;
            adr_q     <= '0;
            wdat_q    <= '0;
            we_q      <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdat_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            wait_q    <= wait_d;
            adr_q     <= adr_d;
            wdat_q    <= wdat_d;
            we_q      <= we_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdat_q    <= rdat_d;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        wait_d    = wait_q;
        adr_d     = adr_q;
        wdat_d    = wdat_q;
        we_d      = we_q;
        case (state_q)
            ST_INIT: begin
                if (clr_cnt_q == LAST_IDX) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                // A clear wins; a simultaneous request is left for the master to hold.
                if (CLR_I) begin
                    state_d = ST_INIT;
                end else if (CYC_I && STB_I) begin
                    adr_d   = ADR_I;
                    wdat_d  = DAT_I;
                    we_d    = WE_I;
                    wait_d  = WAIT_LOAD;
                    state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (!(CYC_I && STB_I)) begin
                    state_d = ST_IDLE;
                end else if (wait_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_INIT;
        endcase
    end

    // Response flops load on the RESP->IDLE edge, together with the memory write.
    always_comb begin
        ack_d     = 1'b0;
        err_d     = 1'b0;
        rdat_d    = '0;
        mem_we    = 1'b0;
        mem_waddr = clr_cnt_q;
        mem_wdata = CLEAR_VAL;
        case (state_q)
            ST_INIT: mem_we = 1'b1;
            ST_RESP: begin
                if (oor) begin
                    err_d = 1'b1;
                end else begin
                    ack_d = 1'b1;
                    if (we_q) begin
                        mem_we    = 1'b1;
                        mem_waddr = adr_idx;
                        mem_wdata = wdat_q;
                    end else begin
                        rdat_d = mem[adr_idx];
                    end
                end
            end
            default: ;
        endcase
    end

    assign ACK_O  = ack_q;
    assign ERR_O  = err_q;
    assign DAT_O  = rdat_q;
    assign BUSY_O = (state_q == ST_INIT);

endmodule
